// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller: divided output div_out plus a tick
// strobe on the first cycle of every high phase; ratio loaded via valid/ready.
// Ports: clk/reset (sync, active-high); en run request; cfg_valid/cfg_div/
// cfg_ready ratio handshake with cfg_err illegal-ratio pulse; div_out, tick,
// cur_div (ratio in use), running (not idle). All outputs are registered.
// Latency: one cycle from en (in idle) to first high cycle; new ratios apply
// at period boundaries. Backpressure: cfg_ready low while a ratio is pending.
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] h_len, h_len_n;
    logic [CNT_W-1:0] l_len, l_len_n;
    logic [CNT_W-1:0] pend_div, pend_div_n;
    logic             pend_vld, pend_vld_n;
    logic [CNT_W-1:0] cur_div_n;
    logic             div_out_n, tick_n, cfg_err_n;
    logic             boundary, apply, xfer;
    logic [CNT_W-1:0] start_div;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        h_len_n    = h_len;
        l_len_n    = l_len;
        pend_div_n = pend_div;
        pend_vld_n = pend_vld;
        cur_div_n  = cur_div;
        div_out_n  = div_out;
        tick_n     = 1'b0;
        boundary   = 1'b0;
        xfer       = cfg_valid && cfg_ready;
        cfg_err_n  = xfer && (cfg_div < TWO);

        // Last cycle of the low phase ends the period.
        if (state == LOW && cnt == l_len - ONE) begin
            boundary = 1'b1;
        end

        // Pending ratio is applied at once in idle, otherwise only at the
        // period boundary so the running period is never cut short.
        apply = pend_vld && (state == IDLE || boundary);

        // A period started out of idle keeps the old ratio even if a pending
        // one is being applied on the same edge; out of LOW it takes the new.
        start_div = (apply && state == LOW) ? pend_div : cur_div;

        if (apply) begin
            cur_div_n  = pend_div;
            pend_vld_n = 1'b0;
        end

        case (state)
            IDLE: begin
                div_out_n = 1'b0;
                if (en) begin
                    state_n   = HIGH;
                    div_out_n = 1'b1;
                    tick_n    = 1'b1;
                    cnt_n     = '0;
                    h_len_n   = start_div - (start_div >> 1);
                    l_len_n   = start_div >> 1;
                end
            end
            HIGH: begin
                if (cnt == h_len - ONE) begin
                    state_n   = LOW;
                    div_out_n = 1'b0;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            LOW: begin
                if (boundary) begin
                    cnt_n = '0;
                    if (en) begin
                        state_n   = HIGH;
                        div_out_n = 1'b1;
                        tick_n    = 1'b1;
                        h_len_n   = start_div - (start_div >> 1);
                        l_len_n   = start_div >> 1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n   = IDLE;
                div_out_n = 1'b0;
                cnt_n     = '0;
            end
        endcase

        // cfg_ready is low whenever a ratio is pending, so a transfer never
        // coincides with an apply on the same edge.
        if (xfer && !cfg_err_n) begin
            pend_div_n = cfg_div;
            pend_vld_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            h_len     <= DEF_DIV - (DEF_DIV >> 1);
            l_len     <= DEF_DIV >> 1;
            pend_div  <= '0;
            pend_vld  <= 1'b0;
            cur_div   <= DEF_DIV;
            div_out   <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            h_len     <= h_len_n;
            l_len     <= l_len_n;
            pend_div  <= pend_div_n;
            pend_vld  <= pend_vld_n;
            cur_div   <= cur_div_n;
            div_out   <= div_out_n;
            tick      <= tick_n;
            cfg_err   <= cfg_err_n;
            cfg_ready <= !pend_vld_n;
            running   <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl: table-driven vectors for idle config,
// 3-cycle pattern and illegal ratios, plus hand sequences for mid-period
// reconfiguration, en drop/reassert and reset with a pending ratio.
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_out;
    logic             tick;
    logic [CNT_W-1:0] cur_div;
    logic             running;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             v;
        logic [CNT_W-1:0] div;
        logic             e_div;
        logic             e_tick;
        logic             e_rdy;
        logic             e_err;
        logic             e_run;
        logic [CNT_W-1:0] e_cur;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic d, input logic t,
                              input logic r, input logic e, input logic ru,
                              input logic [CNT_W-1:0] c);
        chk({tag, " div_out"}, 32'(div_out), 32'(d));
        chk({tag, " tick"}, 32'(tick), 32'(t));
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(r));
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'(e));
        chk({tag, " running"}, 32'(running), 32'(ru));
        chk({tag, " cur_div"}, 32'(cur_div), 32'(c));
    endtask

    initial begin
        // en v div | div tick rdy err run cur
        tbl[0]  = '{0, 1, 16'd3,  0, 0, 0, 0, 0, 16'd10}; // legal load in idle
        tbl[1]  = '{0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd3};  // applied next cycle
        tbl[2]  = '{1, 0, 16'd0,  1, 1, 1, 0, 1, 16'd3};  // start, 2 high
        tbl[3]  = '{1, 0, 16'd0,  1, 0, 1, 0, 1, 16'd3};
        tbl[4]  = '{1, 0, 16'd0,  0, 0, 1, 0, 1, 16'd3};  // 1 low
        tbl[5]  = '{1, 0, 16'd0,  1, 1, 1, 0, 1, 16'd3};
        tbl[6]  = '{1, 0, 16'd0,  1, 0, 1, 0, 1, 16'd3};
        tbl[7]  = '{1, 0, 16'd0,  0, 0, 1, 0, 1, 16'd3};
        tbl[8]  = '{1, 0, 16'd0,  1, 1, 1, 0, 1, 16'd3};
        tbl[9]  = '{0, 0, 16'd0,  1, 0, 1, 0, 1, 16'd3};  // en dropped, period finishes
        tbl[10] = '{0, 0, 16'd0,  0, 0, 1, 0, 1, 16'd3};
        tbl[11] = '{0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd3};  // back to idle
        tbl[12] = '{0, 1, 16'd1,  0, 0, 1, 1, 0, 16'd3};  // illegal 1
        tbl[13] = '{0, 1, 16'd0,  0, 0, 1, 1, 0, 16'd3};  // illegal 0
        tbl[14] = '{0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd3};
        tbl[15] = '{0, 1, 16'd10, 0, 0, 0, 0, 0, 16'd3};  // restore 10
        tbl[16] = '{0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd10};

        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step();
        step();
        expect_all("reset", 0, 0, 1, 0, 0, 16'd10);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; cfg_valid = tbl[i].v; cfg_div = tbl[i].div;
            step();
            expect_all($sformatf("tbl%0d", i), tbl[i].e_div, tbl[i].e_tick,
                       tbl[i].e_rdy, tbl[i].e_err, tbl[i].e_run, tbl[i].e_cur);
        end
        cfg_valid = 1'b0; cfg_div = '0;

        // N=10 running; load 4 in the high phase, second offer must be ignored.
        en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k == 3) begin cfg_valid = 1'b1; cfg_div = 16'd4; end
            if (k == 4) begin cfg_valid = 1'b1; cfg_div = 16'd7; end
            if (k == 10) begin cfg_valid = 1'b0; cfg_div = '0; end
            step();
            if (k < 10)
                expect_all($sformatf("recfg k%0d", k), (k % 10) < 5, (k % 10) == 0,
                           k < 3, 0, 1, 16'd10);
            else
                expect_all($sformatf("recfg k%0d", k), ((k - 10) % 4) < 2,
                           ((k - 10) % 4) == 0, 1, 0, 1, 16'd4);
        end

        // Stop, reload 10 in idle.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!running) break;
        end
        chk("stop running", 32'(running), 32'd0);
        chk("stop div_out", 32'(div_out), 32'd0);
        cfg_valid = 1'b1; cfg_div = 16'd10;
        step();
        cfg_valid = 1'b0; cfg_div = '0;
        step();
        expect_all("reload10", 0, 0, 1, 0, 0, 16'd10);

        // en dropped two cycles into the high phase: full period, then idle.
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) en = 1'b0;
            step();
            if (k < 10)
                expect_all($sformatf("endrop k%0d", k), (k % 10) < 5, (k % 10) == 0,
                           1, 0, 1, 16'd10);
            else
                expect_all($sformatf("endrop k%0d", k), 0, 0, 1, 0, 0, 16'd10);
        end

        // en briefly dropped in the low phase and restored before the boundary.
        for (int k = 0; k < 13; k++) begin
            en = (k == 7) ? 1'b0 : 1'b1;
            step();
            expect_all($sformatf("reen k%0d", k), (k % 10) < 5, (k % 10) == 0,
                       1, 0, 1, 16'd10);
        end

        // Reset mid high phase with a pending ratio.
        cfg_valid = 1'b1; cfg_div = 16'd6;
        step();
        expect_all("pend6", 1, 0, 0, 0, 1, 16'd10);
        cfg_valid = 1'b0; cfg_div = '0;
        reset = 1'b1;
        step();
        expect_all("midreset", 0, 0, 1, 0, 0, 16'd10);
        reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step();
            expect_all($sformatf("postrst k%0d", k), (k % 10) < 5, (k % 10) == 0,
                       1, 0, 1, 16'd10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller. Generates a divided clock-like output `div_out` and a per-period `tick` strobe from `clk`.
- The divide ratio is loaded through a valid/ready config port. A new ratio takes effect only at a period boundary, so there are no runt pulses.
- Start and stop are gated by `en` and are glitch-free.
- Sits between the register/config logic and any slow-clock consumers that need divide ratios other than the fixed one.

Parameters:
- CNT_W, 16, width of divide-ratio and internal counters.
- DEFAULT_DIV, 10, active divide ratio after reset; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- cfg_valid  in  1  new divide ratio offered
- cfg_div  in  CNT_W  requested divide ratio N (output period in clk cycles)
- cfg_ready  out  1  controller can accept a ratio
- cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (<2) and was discarded
- div_out  out  1  divided output
- tick  out  1  one-cycle pulse on the first cycle of each high phase
- cur_div  out  CNT_W  ratio currently in use
- running  out  1  high when state != IDLE

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-period):
  - state=IDLE, div_out=0, tick=0, cfg_err=0, cfg_ready=1.
  - cur_div=DEFAULT_DIV; pending flag cleared; counter=0.
- All outputs are registered.
- Phase split for ratio N:
  - high phase H = N - floor(N/2); low phase L = floor(N/2).
  - Period = N cycles. Examples: N=10 gives 5/5; N=3 gives 2/1; N=2 gives 1/1.
- States:
  - IDLE: div_out=0. If en=1 at an edge: next cycle state=HIGH, div_out=1, tick=1, counter=0.
  - HIGH: counter increments each cycle. When counter==H-1: next state=LOW, div_out=0, counter=0.
  - LOW: counter increments. When counter==L-1, the period boundary:
    - if en=1: next state=HIGH, div_out=1, tick=1, counter=0;
    - else: next state=IDLE.
- en deassertion mid-period: the current period always completes; no shortened high or low phase. Reasserting en before the boundary continues without a gap.
- Config handshake:
  - Transfer occurs on any edge with cfg_valid && cfg_ready.
  - Legal transfer (cfg_div >= 2): stores cfg_div in the pending register and sets the pending flag. cfg_ready=0 from the next cycle until the pending value is applied.
  - Illegal transfer (cfg_div < 2): cfg_err=1 for exactly the next cycle. Nothing is stored, cur_div is unchanged, and cfg_ready stays 1.
- Applying a pending ratio:
  - In IDLE: applied one cycle after the transfer. cur_div updates and cfg_ready returns to 1 on that same edge.
  - In HIGH/LOW: applied at the period boundary edge (LOW end, or LOW->IDLE). The new period's H/L uses the new cur_div.
  - A transfer landing on the same edge as a boundary is not applied at that boundary; it is applied at the next one.
  - IDLE->HIGH with a pending flag set on that edge: the old cur_div is used for the first period.
- cur_div changes only on an apply edge or reset.
- Counter widths: CNT_W bits. H and L are computed from cur_div, latched at each period start. No wrap is possible since counter < H <= cur_div.
- Max ratio is 2^CNT_W-1. An odd N puts the extra cycle in the high phase.

Test Plan:
- Reset then en=1 with defaults -> div_out 5 high / 5 low repeating; tick once every 10 cycles, aligned to div_out rising; cur_div=10.
- In IDLE, cfg_div=3 handshake, then en=1 -> cfg_ready low 1 cycle, cur_div=3; pattern 2 high / 1 low; tick every 3 cycles.
- While running N=10, load cfg_div=4 mid high phase -> current 10-cycle period completes intact; next period 2/2; cfg_ready low until that boundary; a second cfg_valid during the wait is not accepted.
- cfg_div=1 then cfg_div=0 -> cfg_err pulses once per transfer; cur_div unchanged; cfg_ready stays 1; output pattern undisturbed.
- en dropped 2 cycles into high phase (N=10) -> 5 high + 5 low complete, then IDLE with div_out=0 and running=0. en reasserted during the low phase -> next period starts with no gap.
- reset asserted mid high phase with a pending ratio -> next cycle div_out=0, tick=0, cur_div=10, cfg_ready=1; pending ratio discarded.
